// File: rtl/fifo_pkg.sv
// Shared sizing and types for the single-clock FIFO wrapper.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [PTR_WIDTH-1:0]  ptr_t;
  typedef logic                  bit_t;

endpackage

// File: rtl/afifo_if.sv
// FIFO client bundle; mdr is the FIFO side, tst is the driver side.
interface afifo_if #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = fifo_pkg::DEPTH
);

  localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                  push;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport mdr (
    input  push, wdata, pop,
    output rdata, full, empty, count, overflow, underflow
  );

  modport tst (
    output push, wdata, pop,
    input  rdata, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = fifo_pkg::DEPTH,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array is never reset; stale words are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_wrapper.sv
// Single-clock FIFO: pointer, flag and error-pulse logic around fifo_mem.
module fifo_wrapper
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = fifo_pkg::DEPTH
) (
  input  logic   wrclk,
  input  logic   arst_n,
  input  logic   rdclk,
  afifo_if.mdr   itf
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  bit_t                  r_overflow;
  bit_t                  r_underflow;

  bit_t                  w_full;
  bit_t                  w_empty;
  bit_t                  w_push_ok;
  bit_t                  w_pop_ok;
  logic [PTR_WIDTH-1:0]  w_count;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_rdclk;

  // rdclk exists only to keep the legacy pinout.
  assign w_unused_rdclk = rdclk;

  // Extra pointer MSB separates full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign w_count = r_wr_ptr - r_rd_ptr;

  assign w_push_ok = itf.push & ~w_full  & ~arst_n;
  assign w_pop_ok  = itf.pop  & ~w_empty & ~arst_n;

  always_ff @(posedge wrclk) begin
    if (arst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      end
      r_overflow  <= itf.push & w_full;
      r_underflow <= itf.pop  & w_empty;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .i_clk   (wrclk),
    .i_rst   (arst_n),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (itf.wdata),
    .i_re    (w_pop_ok),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  assign itf.rdata     = w_rdata;
  assign itf.full      = w_full;
  assign itf.empty     = w_empty;
  assign itf.count     = w_count;
  assign itf.overflow  = r_overflow;
  assign itf.underflow = r_underflow;

endmodule

// File: tb/tb_fifo_wrapper.sv
// Directed bench for fifo_wrapper with a queue-based reference model checked every cycle.
module tb_fifo_wrapper;
  import fifo_pkg::*;

  logic clk   = 1'b0;
  logic rdclk = 1'b0;
  logic rst   = 1'b1;

  afifo_if itf ();

  fifo_wrapper u_dut (
    .wrclk  (clk),
    .arst_n (rst),
    .rdclk  (rdclk),
    .itf    (itf)
  );

  always #5 clk = ~clk;
  always #7 rdclk = ~rdclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of stored words plus the last popped word.
  data_t q[$];
  data_t m_rdata   = '0;
  bit    m_ovf     = 1'b0;
  bit    m_unf     = 1'b0;
  bit    m_valid   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b1;
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      m_ovf = itf.push && was_full;
      m_unf = itf.pop && was_empty;
      if (itf.pop && !was_empty) m_rdata = q.pop_front();
      if (itf.push && !was_full) q.push_back(itf.wdata);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count",     32'(itf.count),     32'(q.size()));
      chk("model_empty",     32'(itf.empty),     32'(q.size() == 0));
      chk("model_full",      32'(itf.full),      32'(q.size() == DEPTH));
      chk("model_rdata",     32'(itf.rdata),     32'(m_rdata));
      chk("model_overflow",  32'(itf.overflow),  32'(m_ovf));
      chk("model_underflow", 32'(itf.underflow), 32'(m_unf));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] d);
    itf.push  = 1'b1;
    itf.pop   = 1'b0;
    itf.wdata = d;
    step();
    itf.push  = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    itf.pop = 1'b1;
    step();
    itf.pop = 1'b0;
    chk(name, 32'(itf.rdata), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    itf.push  = 1'b0;
    itf.pop   = 1'b0;
    itf.wdata = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset then idle.
    repeat (3) step();
    chk("idle_empty", 32'(itf.empty), 32'd1);
    chk("idle_full",  32'(itf.full),  32'd0);
    chk("idle_count", 32'(itf.count), 32'd0);
    chk("idle_rdata", 32'(itf.rdata), 32'd0);

    // Fill with 0x01..0x10, then drain in order.
    for (int i = 0; i < 16; i++) push_word(8'(i + 1));
    chk("fill_full",  32'(itf.full),  32'd1);
    chk("fill_count", 32'(itf.count), 32'd16);
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain_rdata[%0d]", i), 8'(i + 1));
    chk("drain_empty", 32'(itf.empty), 32'd1);

    // Overflow on a full FIFO leaves contents intact.
    for (int i = 0; i < 16; i++) push_word(8'(8'h20 + i));
    push_word(8'hAA);
    chk("ovf_pulse", 32'(itf.overflow), 32'd1);
    chk("ovf_count", 32'(itf.count),    32'd16);
    step();
    chk("ovf_clear", 32'(itf.overflow), 32'd0);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovf_rdata[%0d]", i), 8'(8'h20 + i));

    // Underflow on an empty FIFO leaves rdata intact.
    itf.pop = 1'b1;
    step();
    itf.pop = 1'b0;
    chk("unf_pulse", 32'(itf.underflow), 32'd1);
    chk("unf_rdata", 32'(itf.rdata),     32'h2F);
    step();
    chk("unf_clear", 32'(itf.underflow), 32'd0);

    // Steady-state streaming at count 8 with pointer wrap.
    for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i));
    for (int i = 0; i < 40; i++) begin
      itf.push  = 1'b1;
      itf.pop   = 1'b1;
      itf.wdata = 8'(8'h48 + i);
      step();
      chk($sformatf("stream_count[%0d]", i), 32'(itf.count), 32'd8);
      chk($sformatf("stream_rdata[%0d]", i), 32'(itf.rdata), 32'(8'(8'h40 + i)));
    end
    itf.push = 1'b0;
    itf.pop  = 1'b0;
    for (int i = 0; i < 8; i++) pop_check($sformatf("stream_tail[%0d]", i), 8'(8'h68 + i));

    // Mid-operation reset with a push held high during reset.
    for (int i = 0; i < 5; i++) push_word(8'(8'h70 + i));
    chk("prerst_count", 32'(itf.count), 32'd5);
    rst       = 1'b1;
    itf.push  = 1'b1;
    itf.wdata = 8'h99;
    step();
    rst      = 1'b0;
    itf.push = 1'b0;
    chk("rst_count", 32'(itf.count), 32'd0);
    chk("rst_empty", 32'(itf.empty), 32'd1);
    chk("rst_rdata", 32'(itf.rdata), 32'd0);
    push_word(8'h3C);
    pop_check("rst_3c", 8'h3C);

    // Push+pop on empty: write only, underflow pulses.
    itf.push  = 1'b1;
    itf.pop   = 1'b1;
    itf.wdata = 8'h55;
    step();
    itf.push = 1'b0;
    itf.pop  = 1'b0;
    chk("pp_empty_unf",   32'(itf.underflow), 32'd1);
    chk("pp_empty_count", 32'(itf.count),     32'd1);
    chk("pp_empty_rdata", 32'(itf.rdata),     32'h3C);

    // Push+pop on full: read only, overflow pulses.
    for (int i = 0; i < 15; i++) push_word(8'(8'h80 + i));
    chk("pp_full_pre", 32'(itf.full), 32'd1);
    itf.push  = 1'b1;
    itf.pop   = 1'b1;
    itf.wdata = 8'hBB;
    step();
    itf.push = 1'b0;
    itf.pop  = 1'b0;
    chk("pp_full_ovf",   32'(itf.overflow), 32'd1);
    chk("pp_full_count", 32'(itf.count),    32'd15);
    chk("pp_full_rdata", 32'(itf.rdata),    32'h55);
    for (int i = 0; i < 15; i++) pop_check($sformatf("pp_full_tail[%0d]", i), 8'(8'h80 + i));
    chk("final_empty", 32'(itf.empty), 32'd1);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wrapper.md
FIFO_WRAPPER -- requirements
Module: fifo_wrapper

Interface
REQ-001 Parameter DATA_WIDTH, default 8, FIFO word width in bits (from fifo_pkg).
REQ-002 Parameter DEPTH, default 16, number of storage words; power of two, at least 2.
REQ-003 Port wrclk, input, 1, the single clock for both the write and read sides; all logic SHALL be rising-edge triggered on wrclk.
REQ-004 Port arst_n, input, 1, reset; synchronous to wrclk and active-high.
REQ-005 Port rdclk, input, 1, retained for pin compatibility only; it SHALL be ignored.
REQ-006 Port itf, interface afifo_if, modport mdr; the block SHALL connect only through this modport.
REQ-007 itf.push, input, 1, write request.
REQ-008 itf.wdata, input, DATA_WIDTH, write data.
REQ-009 itf.pop, input, 1, read request.
REQ-010 itf.rdata, output, DATA_WIDTH, registered read data.
REQ-011 itf.full, output, 1, high when DEPTH words are stored.
REQ-012 itf.empty, output, 1, high when 0 words are stored.
REQ-013 itf.count, output, ADDR_WIDTH+1, current occupancy, 0..DEPTH.
REQ-014 itf.overflow and itf.underflow, outputs, 1 each, single-cycle error pulses.

Function
REQ-015 A write SHALL be accepted on an edge where push=1 and full=0; wdata SHALL be stored at wr_ptr, and wr_ptr SHALL increment.
REQ-016 A read SHALL be accepted on an edge where pop=1 and empty=0; mem[rd_ptr] SHALL be loaded into rdata on that edge and become visible the following cycle (1-cycle latency); rd_ptr SHALL increment.
REQ-017 rdata SHALL hold its last value when no read is accepted.
REQ-018 Pointers SHALL be ADDR_WIDTH+1 bits, where ADDR_WIDTH=$clog2(DEPTH), and SHALL wrap modulo 2*DEPTH; the memory index SHALL be the lower ADDR_WIDTH bits.
REQ-019 empty SHALL be 1 when wr_ptr==rd_ptr; full SHALL be 1 when the MSBs differ and the lower bits are equal; count SHALL equal wr_ptr-rd_ptr (modulo 2*DEPTH).
REQ-020 Flags and count SHALL be derived from registered pointers, so they update in the cycle after the accepting edge.
REQ-021 Simultaneous push and pop when neither full nor empty: both SHALL be accepted, and count SHALL be unchanged.
REQ-022 Simultaneous push and pop when full: only the read SHALL be accepted, and overflow SHALL pulse.
REQ-023 Simultaneous push and pop when empty: only the write SHALL be accepted, and underflow SHALL pulse; there SHALL be no fall-through.
REQ-024 overflow SHALL be 1 for exactly one cycle after an edge with push=1 and full=1.
REQ-025 underflow SHALL be 1 for exactly one cycle after an edge with pop=1 and empty=1.
REQ-026 Rejected requests SHALL NOT alter the pointers, the memory, or rdata.

Reset
REQ-027 While arst_n=1 at a rising edge of wrclk, the following SHALL be set: wr_ptr=0, rd_ptr=0, rdata=0, empty=1, full=0, count=0, overflow=0, underflow=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored contents at that edge; memory contents need not be cleared.
REQ-029 Push and pop SHALL be ignored on any edge where arst_n=1.

Structure
REQ-030 fifo_pkg SHALL hold DATA_WIDTH, DEPTH, ADDR_WIDTH, data_t (logic [DATA_WIDTH-1:0]), ptr_t and bit_t.
REQ-031 afifo_if SHALL declare all the itf signals, with modport mdr for the DUT and modport tst for the bench (directions reversed).
REQ-032 Storage SHALL be the sub-module fifo_mem: a DEPTH x DATA_WIDTH array with a synchronous write port and a registered read port.
REQ-033 Pointer, flag and error logic SHALL reside in fifo_wrapper.

Verification
REQ-034 Reset, then idle for 3 cycles: empty=1, full=0, count=0, rdata=0.
REQ-035 Push 0x01..0x10 (16 words), then pop 16: full=1 after the 16th push; rdata SHALL return 0x01..0x10 in order, each 1 cycle after its pop; empty=1 at the end.
REQ-036 On a full FIFO, push 0xAA: overflow=1 for 1 cycle, count=16, and the contents SHALL be unchanged.
REQ-037 On an empty FIFO, pop: underflow=1 for 1 cycle, and rdata SHALL be unchanged.
REQ-038 With count=8, push and pop together for 40 cycles: count SHALL stay at 8 throughout, the pointers SHALL wrap, and the data order SHALL be preserved.
REQ-039 With count=5, assert reset for 1 cycle: count=0 and empty=1 the next cycle; a subsequent push 0x3C followed by a pop SHALL return 0x3C.
